// File: rtl/can_pkg.sv
// ============================================================================
//  Module      : can_pkg
//  Description : Shared definitions for the extended-frame CAN receiver:
//                receiver state encoding, error codes, CRC-15 polynomial,
//                field lengths and identifier bit positions (the identifier
//                layout is common with the transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package can_pkg;

    // Receiver states, in bus order
    typedef enum logic [3:0] {
        ST_WAIT_IDLE = 4'd0,
        ST_IDLE      = 4'd1,
        ST_ARB_A     = 4'd2,
        ST_SRR_IDE   = 4'd3,
        ST_ARB_B     = 4'd4,
        ST_RTR       = 4'd5,
        ST_R1        = 4'd6,
        ST_R0        = 4'd7,
        ST_DLC       = 4'd8,
        ST_DATA      = 4'd9,
        ST_CRC       = 4'd10,
        ST_CRC_DEL   = 4'd11,
        ST_ACK_SLOT  = 4'd12,
        ST_ACK_DEL   = 4'd13,
        ST_EOF       = 4'd14
    } can_rx_state_t;

    // Error codes reported on rx_err_code_o
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_STUFF = 2'd1;
    localparam logic [1:0] ERR_FORM  = 2'd2;
    localparam logic [1:0] ERR_CRC   = 2'd3;

    localparam logic [14:0] CRC15_POLY = 15'h4599;

    // Field lengths in destuffed bits
    localparam logic [5:0] LEN_ARB_A   = 6'd11;
    localparam logic [5:0] LEN_SRR_IDE = 6'd2;
    localparam logic [5:0] LEN_ARB_B   = 6'd18;
    localparam logic [5:0] LEN_DLC     = 6'd4;
    localparam logic [5:0] LEN_CRC     = 6'd15;
    localparam logic [5:0] LEN_EOF     = 6'd7;

    // Bit positions of the team fields inside the 29-bit identifier
    localparam int ID_TYPE_POS = 28;
    localparam int ID_SRC_LSB  = 22;
    localparam int ID_DST_LSB  = 16;
    localparam int ID_HS_LSB   = 14;
    localparam int ID_ATTR_LSB = 12;
    localparam int ID_EXP_LSB  = 8;
    localparam int ID_CMD_LSB  = 0;

    // One serial CRC-15 step, MSB-first
    function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic din);
        logic [14:0] shifted;
        shifted = {crc[13:0], 1'b0};
        return (din ^ crc[14]) ? (shifted ^ CRC15_POLY) : shifted;
    endfunction

endpackage

`default_nettype wire

// File: rtl/can_crc15.sv
// ============================================================================
//  Module      : can_crc15
//  Description : Serial CRC-15 register (polynomial 0x4599, init 0).
//  Ports       : clk_can  - bit clock
//                rst_i    - asynchronous reset, active-high
//                clr_i    - synchronous clear to the init value
//                en_i     - shift bit_i into the register this cycle
//                bit_i    - serial data bit
//                crc_o    - current CRC value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_crc15
    import can_pkg::*;
(
    input  logic        clk_can,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [14:0] crc_o
);

    logic [14:0] r_crc;

    always_ff @(posedge clk_can or posedge rst_i) begin
        if (rst_i) begin
            r_crc <= '0;
        end else if (clr_i) begin
            r_crc <= '0;
        end else if (en_i) begin
            r_crc <= crc15_next(r_crc, bit_i);
        end
    end

    assign crc_o = r_crc;

endmodule

`default_nettype wire

// File: rtl/can_rx_frame_decoder.sv
// ============================================================================
//  Module      : can_rx_frame_decoder
//  Description : Bit-level receiver for extended CAN frames. Samples one bus
//                bit per clk_can cycle, destuffs, checks CRC-15 and form,
//                drives the ACK bit and unpacks the identifier into the
//                address/command fields.
//  Ports       : clk_can, rst_i (async, active-high), rx_i (0 = dominant)
//                tx_ack_o      - ACK drive, 0 = dominant
//                rx_busy_o     - frame in progress
//                rx_valid_o    - one-cycle pulse, frame accepted
//                rx_err_o      - one-cycle pulse, frame aborted
//                rx_err_code_o - 1 stuff, 2 form, 3 crc
//                message_type_o .. cmd_data_sign_o - identifier fields
//                rtr_o, dlc_o, data_o (byte 0 in [63:56])
//  Config      : CAN_RX_ACK_EN - when defined the receiver drives the ACK
//                slot; otherwise tx_ack_o is tied recessive (listen-only).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_rx_frame_decoder
    import can_pkg::*;
#(
    parameter int IDLE_BITS = 11,
    parameter int MAX_BYTES = 8
) (
    input  logic        clk_can,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        tx_ack_o,
    output logic        rx_busy_o,
    output logic        rx_valid_o,
    output logic        rx_err_o,
    output logic [1:0]  rx_err_code_o,
    output logic        message_type_o,
    output logic [5:0]  src_address_o,
    output logic [5:0]  dst_address_o,
    output logic [1:0]  handshake_o,
    output logic [1:0]  attribute_o,
    output logic [3:0]  expand_count_o,
    output logic [7:0]  cmd_data_sign_o,
    output logic        rtr_o,
    output logic [3:0]  dlc_o,
    output logic [63:0] data_o
);

    localparam int                IDLE_W    = $clog2(IDLE_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [3:0]        MAX_DLC   = 4'(MAX_BYTES);

    can_rx_state_t     r_state, w_state_nxt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [5:0]        r_bit_cnt;
    logic              r_last_bit;
    logic [2:0]        r_run_cnt;
    logic [28:0]       r_id;
    logic              r_rtr;
    logic [3:0]        r_dlc;
    logic [63:0]       r_data;
    logic [14:0]       r_crc_rx;
    logic [14:0]       w_crc_calc;

    logic              w_in_region, w_stuff_bit, w_stuff_err, w_bit_use;
    logic              w_sof, w_crc_en, w_crc_ok;
    logic [3:0]        w_dlc_full, w_bytes;
    logic [6:0]        w_data_last;
    logic              w_valid, w_err;
    logic [1:0]        w_err_code;

    logic              r_valid, r_err;
    logic [1:0]        r_err_code;
    logic              r_message_type, r_rtr_o;
    logic [5:0]        r_src, r_dst;
    logic [1:0]        r_hs, r_attr;
    logic [3:0]        r_exp, r_dlc_o;
    logic [7:0]        r_cmd;
    logic [63:0]       r_data_o;

    // Stuffing covers SOF through the last CRC bit; SOF seeds the run tracker
    assign w_in_region = r_state inside {ST_ARB_A, ST_SRR_IDE, ST_ARB_B, ST_RTR,
                                         ST_R1, ST_R0, ST_DLC, ST_DATA, ST_CRC};
    assign w_stuff_bit = w_in_region && (r_run_cnt == 3'd5);
    assign w_stuff_err = w_stuff_bit && (rx_i == r_last_bit);
    assign w_bit_use   = !w_stuff_bit;
    assign w_sof       = (r_state == ST_IDLE) && !rx_i;
    assign w_crc_en    = w_bit_use && (r_state inside {ST_ARB_A, ST_SRR_IDE, ST_ARB_B,
                                                       ST_RTR, ST_R1, ST_R0, ST_DLC, ST_DATA});
    assign w_crc_ok    = (r_crc_rx == w_crc_calc);

    // DLC decision needs the value including the bit being sampled now
    assign w_dlc_full  = {r_dlc[2:0], rx_i};
    assign w_bytes     = (r_dlc > MAX_DLC) ? MAX_DLC : r_dlc;
    assign w_data_last = {w_bytes, 3'b000} - 7'd1;

    can_crc15 u_crc (
        .clk_can (clk_can),
        .rst_i   (rst_i),
        .clr_i   (w_sof),
        .en_i    (w_crc_en),
        .bit_i   (rx_i),
        .crc_o   (w_crc_calc)
    );

    always_ff @(posedge clk_can or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        if (w_stuff_err) begin
            w_err       = 1'b1;
            w_err_code  = ERR_STUFF;
            w_state_nxt = ST_WAIT_IDLE;
        end else if (w_bit_use) begin
            case (r_state)
                ST_WAIT_IDLE: if (rx_i && (r_idle_cnt == IDLE_LAST)) w_state_nxt = ST_IDLE;
                ST_IDLE:      if (!rx_i) w_state_nxt = ST_ARB_A;
                ST_ARB_A:     if (r_bit_cnt == LEN_ARB_A - 6'd1) w_state_nxt = ST_SRR_IDE;
                ST_SRR_IDE: begin
                    // Both SRR and IDE must be recessive: standard frames are rejected
                    if (!rx_i) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_FORM;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else if (r_bit_cnt == LEN_SRR_IDE - 6'd1) begin
                        w_state_nxt = ST_ARB_B;
                    end
                end
                ST_ARB_B:     if (r_bit_cnt == LEN_ARB_B - 6'd1) w_state_nxt = ST_RTR;
                ST_RTR:       w_state_nxt = ST_R1;
                ST_R1:        w_state_nxt = ST_R0;
                ST_R0:        w_state_nxt = ST_DLC;
                ST_DLC: begin
                    if (r_bit_cnt == LEN_DLC - 6'd1) begin
                        w_state_nxt = (r_rtr || (w_dlc_full == 4'd0)) ? ST_CRC : ST_DATA;
                    end
                end
                ST_DATA:      if ({1'b0, r_bit_cnt} == w_data_last) w_state_nxt = ST_CRC;
                ST_CRC:       if (r_bit_cnt == LEN_CRC - 6'd1) w_state_nxt = ST_CRC_DEL;
                ST_CRC_DEL: begin
                    if (!w_crc_ok) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_CRC;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else if (!rx_i) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_FORM;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        w_state_nxt = ST_ACK_SLOT;
                    end
                end
                ST_ACK_SLOT:  w_state_nxt = ST_ACK_DEL;
                ST_ACK_DEL: begin
                    if (!rx_i) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_FORM;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        w_state_nxt = ST_EOF;
                    end
                end
                ST_EOF: begin
                    // The last EOF bit is not checked
                    if (r_bit_cnt == LEN_EOF - 6'd1) begin
                        w_valid     = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else if (!rx_i) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_FORM;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
                default:      w_state_nxt = ST_WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_can or posedge rst_i) begin
        if (rst_i) begin
            r_idle_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_last_bit     <= 1'b1;
            r_run_cnt      <= '0;
            r_id           <= '0;
            r_rtr          <= 1'b0;
            r_dlc          <= '0;
            r_data         <= '0;
            r_crc_rx       <= '0;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_message_type <= 1'b0;
            r_src          <= '0;
            r_dst          <= '0;
            r_hs           <= '0;
            r_attr         <= '0;
            r_exp          <= '0;
            r_cmd          <= '0;
            r_rtr_o        <= 1'b0;
            r_dlc_o        <= '0;
            r_data_o       <= '0;
        end else begin
            r_valid <= w_valid;
            r_err   <= w_err;
            if (w_err) r_err_code <= w_err_code;

            r_idle_cnt <= (r_state == ST_WAIT_IDLE && rx_i) ? r_idle_cnt + 1'b1 : '0;

            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_use) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            // Run tracking counts stuff bits too
            if (w_sof) begin
                r_last_bit <= 1'b0;
                r_run_cnt  <= 3'd1;
            end else if (w_in_region) begin
                r_last_bit <= rx_i;
                r_run_cnt  <= (w_stuff_bit || (rx_i != r_last_bit)) ? 3'd1 : r_run_cnt + 3'd1;
            end

            if (w_sof) begin
                r_id     <= '0;
                r_rtr    <= 1'b0;
                r_dlc    <= '0;
                r_data   <= '0;
                r_crc_rx <= '0;
            end else if (w_bit_use) begin
                case (r_state)
                    ST_ARB_A, ST_ARB_B: r_id            <= {r_id[27:0], rx_i};
                    ST_RTR:             r_rtr           <= rx_i;
                    ST_DLC:             r_dlc           <= w_dlc_full;
                    ST_DATA:            r_data[6'd63 - r_bit_cnt] <= rx_i;
                    ST_CRC:             r_crc_rx        <= {r_crc_rx[13:0], rx_i};
                    default: ;
                endcase
            end

            if (w_valid) begin
                r_message_type <= r_id[ID_TYPE_POS];
                r_src          <= r_id[ID_SRC_LSB  +: 6];
                r_dst          <= r_id[ID_DST_LSB  +: 6];
                r_hs           <= r_id[ID_HS_LSB   +: 2];
                r_attr         <= r_id[ID_ATTR_LSB +: 2];
                r_exp          <= r_id[ID_EXP_LSB  +: 4];
                r_cmd          <= r_id[ID_CMD_LSB  +: 8];
                r_rtr_o        <= r_rtr;
                r_dlc_o        <= r_dlc;
                r_data_o       <= r_data;
            end
        end
    end

`ifdef CAN_RX_ACK_EN
    // Dominant for exactly the cycle following an accepted CRC delimiter
    logic r_tx_ack;

    always_ff @(posedge clk_can or posedge rst_i) begin
        if (rst_i) begin
            r_tx_ack <= 1'b1;
        end else begin
            r_tx_ack <= !((r_state == ST_CRC_DEL) && rx_i && w_crc_ok);
        end
    end

    assign tx_ack_o = r_tx_ack;
`else
    assign tx_ack_o = 1'b1;
`endif

    assign rx_busy_o       = !(r_state inside {ST_WAIT_IDLE, ST_IDLE}) || r_valid || r_err;
    assign rx_valid_o      = r_valid;
    assign rx_err_o        = r_err;
    assign rx_err_code_o   = r_err_code;
    assign message_type_o  = r_message_type;
    assign src_address_o   = r_src;
    assign dst_address_o   = r_dst;
    assign handshake_o     = r_hs;
    assign attribute_o     = r_attr;
    assign expand_count_o  = r_exp;
    assign cmd_data_sign_o = r_cmd;
    assign rtr_o           = r_rtr_o;
    assign dlc_o           = r_dlc_o;
    assign data_o          = r_data_o;

endmodule

`default_nettype wire
